hfg_denormalization_23x23: RTL and testbench



---
 rtl/hfg_norm_pkg.sv | 9 +
 rtl/hfg_restoring_div.sv | 49 ++++
 rtl/hfg_denormalization_23x23.sv | 88 ++++++++
 tb/tb_hfg_denormalization_23x23.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hfg_norm_pkg.sv
// hfg_norm_pkg: shared constants and FSM states for the 23x23 Haar feature normalization path
package hfg_norm_pkg;
  localparam int NORM_DIVISOR = 7959;
  localparam int NORM_SHIFT = 6;
  localparam int PRE_W = 21;
  localparam int FEAT_W = 32;
  localparam int DVD_W = 38;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/hfg_restoring_div.sv
// hfg_restoring_div: unsigned iterative restoring divider, one quotient bit per cycle, MSB first
module hfg_restoring_div #(
  parameter int DVD_W = 38,
  parameter int DVS_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             last,
  output logic [DVD_W-1:0] q_next
);
  localparam int CW = $clog2(DVD_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(DVD_W - 1);
  logic [DVD_W-1:0] dvd, q;
  logic [DVS_W-1:0] dvs, rem, rem_next;
  logic [DVS_W:0] trial, diff;
  logic [CW-1:0] cnt;
  logic busy, ge;
  assign trial = {rem, dvd[cnt]};
  assign diff = trial - {1'b0, dvs};
  // rem < divisor keeps trial below 2*divisor, so the diff MSB is a clean borrow flag
  assign ge = !diff[DVS_W];
  assign rem_next = ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
  assign q_next = {q[DVD_W-2:0], ge};
  assign last = busy && cnt == '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      dvd <= dividend;
      dvs <= divisor;
      rem <= '0;
      q <= '0;
      cnt <= CNT_MAX;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      q <= q_next;
      cnt <= cnt - 1'b1;
      busy <= cnt != '0;
    end
endmodule

// File: rtl/hfg_denormalization_23x23.sv
// hfg_denormalization_23x23: recovers pre-feature p = sign * ceil(|F| * 2^SHIFT / DIVISOR)
// from a normalized feature; defining HFG_DENORM_SAT_EN clamps to the OUT_W range and adds oSat.
module hfg_denormalization_23x23
  import hfg_norm_pkg::*;
#(
  parameter int DIVISOR = NORM_DIVISOR,
  parameter int SHIFT = NORM_SHIFT,
  parameter int IN_W = FEAT_W,
  parameter int OUT_W = PRE_W,
  parameter int DVD_W = hfg_norm_pkg::DVD_W
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic [IN_W-1:0]  iFeature,
  input  logic             iValid,
  output logic             oReady,
  output logic [OUT_W-1:0] oPre_Feature,
  output logic             oValid,
  input  logic             iReady
`ifdef HFG_DENORM_SAT_EN
  , output logic           oSat
`endif
);
  localparam int REM_W = $clog2(DIVISOR);
  state_t state;
  logic neg, start, last;
  logic [IN_W-1:0] mag;
  logic [DVD_W-1:0] dividend, q_next;
  logic [OUT_W-1:0] pre;
  assign start = oReady && iValid;
  assign mag = iFeature[IN_W-1] ? -iFeature : iFeature;
  // adding DIVISOR-1 turns the floor division into a ceiling
  assign dividend = (DVD_W'(mag) << SHIFT) + DVD_W'(DIVISOR - 1);
  hfg_restoring_div #(.DVD_W(DVD_W), .DVS_W(REM_W)) u_div (
    .clk(iClk),
    .rst_n(iReset_n),
    .start(start),
    .dividend(dividend),
    .divisor(REM_W'(DIVISOR)),
    .last(last),
    .q_next(q_next)
  );
`ifdef HFG_DENORM_SAT_EN
  logic [DVD_W-1:0] limit;
  logic [OUT_W-1:0] pre_mag;
  logic sat;
  assign limit = neg ? DVD_W'(1) << (OUT_W - 1) : (DVD_W'(1) << (OUT_W - 1)) - 1'b1;
  assign sat = q_next > limit;
  assign pre_mag = sat ? limit[OUT_W-1:0] : q_next[OUT_W-1:0];
  assign pre = neg ? -pre_mag : pre_mag;
`else
  logic unused_hi;
  assign unused_hi = ^q_next[DVD_W-1:OUT_W];
  assign pre = neg ? -q_next[OUT_W-1:0] : q_next[OUT_W-1:0];
`endif
  always_ff @(posedge iClk)
    if (!iReset_n) begin
      state <= IDLE;
      oReady <= 1'b1;
      oValid <= 1'b0;
      oPre_Feature <= '0;
      neg <= 1'b0;
`ifdef HFG_DENORM_SAT_EN
      oSat <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (start) begin
          neg <= iFeature[IN_W-1];
          oReady <= 1'b0;
          state <= DIV;
        end
        DIV: if (last) begin
          oPre_Feature <= pre;
          oValid <= 1'b1;
`ifdef HFG_DENORM_SAT_EN
          oSat <= sat;
`endif
          state <= DONE;
        end
        DONE: if (iReady) begin
          oValid <= 1'b0;
          oReady <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_hfg_denormalization_23x23.sv
// tb_hfg_denormalization_23x23: vector table, randomized round-trip and raw checks against a ceil-division model
module tb_hfg_denormalization_23x23;
  logic iClk = 1'b0, iReset_n = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [31:0] iFeature = '0;
  logic oReady, oValid;
  logic [20:0] oPre_Feature;
`ifdef HFG_DENORM_SAT_EN
  logic oSat;
`endif
  int checks = 0, passed = 0;

  hfg_denormalization_23x23 dut (
    .iClk(iClk),
    .iReset_n(iReset_n),
    .iFeature(iFeature),
    .iValid(iValid),
    .oReady(oReady),
    .oPre_Feature(oPre_Feature),
    .oValid(oValid),
    .iReady(iReady)
`ifdef HFG_DENORM_SAT_EN
    , .oSat(oSat)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] f;
    logic [20:0] pre;
    logic sat;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // {sat, pre}: |p| = ceil(|F| * 64 / 7959), signed, clamped only when saturation is built in
  function automatic logic [21:0] model(input logic [31:0] f);
    longint unsigned m, q;
    longint v;
    logic s;
    m = f[31] ? 64'h1_0000_0000 - {32'b0, f} : {32'b0, f};
    q = (m * 64 + 7958) / 7959;
    s = 1'b0;
`ifdef HFG_DENORM_SAT_EN
    begin
      longint unsigned lim;
      lim = f[31] ? 64'd1048576 : 64'd1048575;
      if (q > lim) begin s = 1'b1; q = lim; end
    end
`endif
    v = f[31] ? -longint'(q) : longint'(q);
    return {s, v[20:0]};
  endfunction

  function automatic logic [31:0] fwd(input int p);
    longint a, fl;
    a = p < 0 ? -longint'(p) : longint'(p);
    fl = (a * 7959) / 64;
    fl = p < 0 ? -fl : fl;
    return fl[31:0];
  endfunction

  task automatic run(input logic [31:0] f, output logic [20:0] got, output logic gsat);
    int n, lat;
    bit busy_ok, hold_ok;
    logic [20:0] held;
    n = 0;
    while (!oReady && n < 100) begin @(posedge iClk); #1; n++; end
    iFeature = f; iValid = 1'b1;
    @(posedge iClk); #1;
    iFeature = $urandom;
    busy_ok = 1'b1; lat = 0;
    while (!oValid && lat < 60) begin
      if (oReady) busy_ok = 1'b0;
      @(posedge iClk); #1; lat++;
    end
    iValid = 1'b0;
    chk("latency", 64'(lat), 64'd38);
    held = oPre_Feature; hold_ok = 1'b1;
    repeat ($urandom_range(0, 3)) begin
      if (!oValid || oPre_Feature !== held || oReady) hold_ok = 1'b0;
      @(posedge iClk); #1;
    end
    got = oPre_Feature;
`ifdef HFG_DENORM_SAT_EN
    gsat = oSat;
`else
    gsat = 1'b0;
`endif
    if (got !== held) hold_ok = 1'b0;
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    chk("busy_not_ready", 64'(busy_ok), 64'd1);
    chk("hold_stable", 64'(hold_ok), 64'd1);
    chk("handshake_valid_ready", {62'b0, oValid, oReady}, 64'b01);
  endtask

  initial begin
    logic [20:0] got;
    logic gsat;
    logic [21:0] m;
    tbl[0] = '{32'd124359, 21'd1000, 1'b0};
    tbl[1] = '{-32'sd124359, 21'h1FFC18, 1'b0};
    tbl[2] = '{32'd124, 21'd1, 1'b0};
    tbl[3] = '{32'd0, 21'd0, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 21'h1FFFFF, 1'b0};
    tbl[5] = '{-32'sd130400256, 21'h100000, 1'b0};
    tbl[6] = '{32'd130400131, 21'h0FFFFF, 1'b0};
`ifdef HFG_DENORM_SAT_EN
    tbl[7] = '{32'h7FFFFFFF, 21'h0FFFFF, 1'b1};
    tbl[8] = '{32'h80000000, 21'h100000, 1'b1};
    tbl[9] = '{32'd130400256, 21'h0FFFFF, 1'b1};
`else
    tbl[7] = '{32'h7FFFFFFF, 21'h077E92, 1'b0};
    tbl[8] = '{32'h80000000, 21'h18816E, 1'b0};
    tbl[9] = '{32'd130400256, 21'h100000, 1'b0};
`endif
    repeat (2) @(posedge iClk);
    #1;
    chk("reset_ready", 64'(oReady), 64'd1);
    chk("reset_valid", 64'(oValid), 64'd0);
    chk("reset_pre", 64'(oPre_Feature), 64'd0);
`ifdef HFG_DENORM_SAT_EN
    chk("reset_sat", 64'(oSat), 64'd0);
`endif
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    for (int i = 0; i < 10; i++) begin
      run(tbl[i].f, got, gsat);
      chk($sformatf("tbl_pre[%0d]", i), 64'(got), 64'(tbl[i].pre));
`ifdef HFG_DENORM_SAT_EN
      chk($sformatf("tbl_sat[%0d]", i), 64'(gsat), 64'(tbl[i].sat));
`endif
    end
    for (int i = 0; i < 300; i++) begin
      int p;
      logic [31:0] pv;
      p = int'($urandom_range(0, 2097151)) - 1048576;
      if (i == 0) p = -1048576;
      if (i == 1) p = 1048575;
      if (i == 2) p = -1;
      pv = p;
      run(fwd(p), got, gsat);
      chk("roundtrip", 64'(got), 64'(pv[20:0]));
`ifdef HFG_DENORM_SAT_EN
      chk("roundtrip_sat", 64'(gsat), 64'd0);
`endif
    end
    for (int i = 0; i < 200; i++) begin
      logic [31:0] f;
      f = $urandom;
      if (i % 4 == 1) f = $urandom_range(0, 300000);
      if (i % 4 == 2) f = -$urandom_range(0, 300000);
      m = model(f);
      run(f, got, gsat);
      chk("raw_pre", 64'(got), 64'(m[20:0]));
`ifdef HFG_DENORM_SAT_EN
      chk("raw_sat", 64'(gsat), 64'(m[21]));
`endif
    end
    // abort a division ten cycles in, then make sure the next result is clean
    iFeature = 32'd124359; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (10) begin @(posedge iClk); #1; end
    iReset_n = 1'b0;
    @(posedge iClk); #1;
    chk("abort_valid", 64'(oValid), 64'd0);
    chk("abort_ready", 64'(oReady), 64'd1);
    chk("abort_pre", 64'(oPre_Feature), 64'd0);
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    run(32'd124, got, gsat);
    chk("post_abort_pre", 64'(got), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
